// File: rtl/apb_timer_nch_if.sv
// APB slave bus bundle for apb_timer_nch (10-bit word address, 32-bit data).
interface apb_timer_nch_if;
    logic        PSEL;
    logic [11:2] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_nch.sv
// NCH-channel APB timer: per-channel prescaler, compare, W1C raw status and masked IRQ.
// Define TIMER_ONESHOT_EN to implement CTRL.ONESHOT; otherwise every channel is periodic.
module apb_timer_nch #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PW    = 16
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_timer_nch_if.slave apb,
    output logic           IRQ,
    output logic [NCH-1:0] TMR_EVT
);
    localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

    logic [WIDTH-1:0] r_cnt [NCH];
    logic [PW-1:0]    r_pc  [NCH];
    logic [PW-1:0]    r_pre [NCH];
    logic [WIDTH-1:0] r_cmp [NCH];
    logic [NCH-1:0]   r_en;
    logic [NCH-1:0]   r_ris;
    logic [NCH-1:0]   r_irqen;
    logic [NCH-1:0]   r_evt;
`ifdef TIMER_ONESHOT_EN
    logic [NCH-1:0]   r_os;
`endif

    logic [NCH-1:0]   w_os;
    logic [NCH-1:0]   w_tick;
    logic [NCH-1:0]   w_match;
    logic [NCH-1:0]   w_wr_cnt;
    logic [NCH-1:0]   w_wr_pre;
    logic [NCH-1:0]   w_wr_cmp;
    logic [NCH-1:0]   w_wr_ctrl;
    logic [NCH-1:0]   w_w1c;
    logic             w_wr;
    logic             w_rd;
    logic [3:0]       w_idx;
    logic [1:0]       w_reg;
    logic             w_ch_ok;
    logic             w_g_irqen;
    logic             w_g_ris;
    logic             w_g_mis;
    logic             w_mapped;
    logic [31:0]      w_rdata;

`ifdef TIMER_ONESHOT_EN
    assign w_os = r_os;
`else
    assign w_os = '0;
`endif

    assign w_wr      = apb.PSEL & apb.PWRITE & apb.PENABLE;
    assign w_rd      = apb.PSEL & ~apb.PWRITE;
    assign w_idx     = apb.PADDR[7:4];
    assign w_reg     = apb.PADDR[3:2];
    assign w_ch_ok   = (apb.PADDR[11:8] == 4'd0) && (32'(w_idx) < NCH);
    assign w_g_irqen = (apb.PADDR == 10'h040);
    assign w_g_ris   = (apb.PADDR == 10'h041);
    assign w_g_mis   = (apb.PADDR == 10'h042);
    assign w_mapped  = w_ch_ok | w_g_irqen | w_g_ris | w_g_mis;
    assign w_w1c     = (w_wr && w_g_ris) ? apb.PWDATA[NCH-1:0] : '0;

    always_comb begin
        w_wr_cnt  = '0;
        w_wr_pre  = '0;
        w_wr_cmp  = '0;
        w_wr_ctrl = '0;
        w_tick    = '0;
        w_match   = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (w_wr && w_ch_ok && (32'(w_idx) == c)) begin
                case (w_reg)
                    2'd0:    w_wr_cnt[c]  = 1'b1;
                    2'd1:    w_wr_pre[c]  = 1'b1;
                    2'd2:    w_wr_cmp[c]  = 1'b1;
                    default: w_wr_ctrl[c] = 1'b1;
                endcase
            end
            w_tick[c]  = r_en[c] && (r_pc[c] == r_pre[c]);
            // A CNT write on a tick edge suppresses that tick's match.
            w_match[c] = w_tick[c] && (r_cnt[c] == r_cmp[c]) && !w_wr_cnt[c];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_cnt[c] <= '0;
                r_pc[c]  <= '0;
                r_pre[c] <= '0;
                r_cmp[c] <= '0;
            end
            r_en    <= '0;
            r_ris   <= '0;
            r_irqen <= '0;
            r_evt   <= '0;
`ifdef TIMER_ONESHOT_EN
            r_os    <= '0;
`endif
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (w_wr_cnt[c]) begin
                    r_cnt[c] <= apb.PWDATA[WIDTH-1:0];
                    r_pc[c]  <= '0;
                end else if (r_en[c]) begin
                    if (w_tick[c]) begin
                        r_pc[c]  <= '0;
                        r_cnt[c] <= w_match[c] ? '0 : r_cnt[c] + WIDTH'(1);
                    end else begin
                        r_pc[c]  <= r_pc[c] + PW'(1);
                    end
                end
                if (w_wr_pre[c]) r_pre[c] <= apb.PWDATA[PW-1:0];
                if (w_wr_cmp[c]) r_cmp[c] <= apb.PWDATA[WIDTH-1:0];
                if (w_wr_ctrl[c]) begin
                    r_en[c] <= apb.PWDATA[0];
`ifdef TIMER_ONESHOT_EN
                    r_os[c] <= apb.PWDATA[1];
`endif
                end else if (w_match[c] && w_os[c]) begin
                    r_en[c] <= 1'b0;
                end
            end
            if (w_wr && w_g_irqen) r_irqen <= apb.PWDATA[NCH-1:0];
            // Hardware set takes priority over a same-cycle software clear.
            r_ris <= (r_ris & ~w_w1c) | w_match;
            r_evt <= w_match;
        end
    end

    always_comb begin
        w_rdata = UNMAPPED;
        if (w_ch_ok) begin
            w_rdata = '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (32'(w_idx) == c) begin
                    case (w_reg)
                        2'd0:    w_rdata = 32'(r_cnt[c]);
                        2'd1:    w_rdata = 32'(r_pre[c]);
                        2'd2:    w_rdata = 32'(r_cmp[c]);
                        default: w_rdata = 32'({w_os[c], r_en[c]});
                    endcase
                end
            end
        end else if (w_g_irqen) begin
            w_rdata = 32'(r_irqen);
        end else if (w_g_ris) begin
            w_rdata = 32'(r_ris);
        end else if (w_g_mis) begin
            w_rdata = 32'(r_ris & r_irqen);
        end
    end

    assign apb.PRDATA  = w_rd ? w_rdata : '0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~w_mapped;
    assign IRQ         = |(r_ris & r_irqen);
    assign TMR_EVT     = r_evt;
endmodule

// File: tb/tb_apb_timer_nch.sv
// Directed self-checking bench for apb_timer_nch (NCH=4, WIDTH=32, PW=16).
module tb_apb_timer_nch;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       irq;
    logic [3:0] evt;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int wr_cyc  = 0;
    int evt_cnt   [4];
    int first_evt [4];
    int last_evt  [4];

    apb_timer_nch_if bus ();

    apb_timer_nch #(.NCH(4), .WIDTH(32), .PW(16)) dut (
        .PCLK    (clk),
        .PRESET  (rst),
        .apb     (bus),
        .IRQ     (irq),
        .TMR_EVT (evt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (evt[c]) begin
                if (evt_cnt[c] == 0) first_evt[c] = cyc;
                last_evt[c] = cyc;
                evt_cnt[c]  = evt_cnt[c] + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic mon_clr();
        for (int c = 0; c < 4; c++) begin
            evt_cnt[c]   = 0;
            first_evt[c] = 0;
            last_evt[c]  = 0;
        end
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        bus.PSEL    = 1'b1;
        bus.PWRITE  = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = a[11:2];
        bus.PWDATA  = d;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        wr_cyc      = cyc;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        bus.PSEL    = 1'b1;
        bus.PWRITE  = 1'b0;
        bus.PENABLE = 1'b1;
        bus.PADDR   = a[11:2];
        @(negedge clk);
        d = bus.PRDATA;
        e = bus.PSLVERR;
        @(posedge clk); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_rd(a, d, e);
        check(tag, d, exp);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          e0;
        int          e1;
        logic [31:0] os_ctrl;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0;  bus.PWDATA = '0;
        mon_clr();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

`ifdef TIMER_ONESHOT_EN
        os_ctrl = 32'h2;
`else
        os_ctrl = 32'h0;
`endif

        // Reset state and decode
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_evt", 32'(evt), 32'h0);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_chk($sformatf("rst_ch%0d_r%0d", c, r), 12'(c * 16 + r * 4), 32'h0);
            end
        end
        rd_chk("rst_irqen", 12'h100, 32'h0);
        rd_chk("rst_ris",   12'h104, 32'h0);
        rd_chk("rst_mis",   12'h108, 32'h0);
        apb_rd(12'h1F0, d, e);
        check("unmapped_data", d, 32'hDEADBEEF);
        check("unmapped_err",  32'(e), 32'h1);
        apb_rd(12'h104, d, e);
        check("mapped_err", 32'(e), 32'h0);
        rd_chk("ch4_unmapped", 12'h040, 32'hDEADBEEF);

        // Field truncation / zero-extension
        apb_wr(12'h024, 32'h1234ABCD);
        rd_chk("pre_trunc", 12'h024, 32'h0000ABCD);
        apb_wr(12'h03C, 32'hFFFFFFFE);
        rd_chk("ctrl_bits", 12'h03C, os_ctrl);
        apb_wr(12'h03C, 32'h0);
        apb_wr(12'h024, 32'h0);
        apb_wr(12'h040, 32'h55);
        rd_chk("ch4_wr_ignored", 12'h040, 32'hDEADBEEF);

        // Periodic ch0: PRE=3, CMP=4 -> period 20
        apb_wr(12'h004, 32'd3);
        apb_wr(12'h008, 32'd4);
        mon_clr();
        apb_wr(12'h00C, 32'h1);
        e0 = wr_cyc;
        wait_cyc(e0 + 45);
        check("per_count",  32'(evt_cnt[0]), 32'd2);
        check("per_first",  32'(first_evt[0] - e0), 32'd20);
        check("per_period", 32'(last_evt[0] - first_evt[0]), 32'd20);
        check("per_others", 32'(evt_cnt[1] + evt_cnt[2] + evt_cnt[3]), 32'd0);
        rd_chk("per_ris", 12'h104, 32'h1);
        check("per_irq_masked", 32'(irq), 32'h0);
        rd_chk("per_ch1_cnt", 12'h010, 32'h0);
        apb_wr(12'h00C, 32'h0);
        apb_wr(12'h104, 32'hF);
        rd_chk("per_ris_clr", 12'h104, 32'h0);

        // One-shot ch1: PRE=0, CMP=9
        apb_wr(12'h014, 32'd0);
        apb_wr(12'h018, 32'd9);
        mon_clr();
        apb_wr(12'h01C, 32'h3);
        e1 = wr_cyc;
        wait_cyc(e1 + 35);
        check("os_first", 32'(first_evt[1] - e1), 32'd10);
`ifdef TIMER_ONESHOT_EN
        check("os_count", 32'(evt_cnt[1]), 32'd1);
        rd_chk("os_ctrl", 12'h01C, 32'h2);
        rd_chk("os_cnt",  12'h010, 32'h0);
`else
        check("os_count", 32'(evt_cnt[1]), 32'd3);
        check("os_period", 32'(last_evt[1] - first_evt[1]), 32'd20);
        rd_chk("os_ctrl", 12'h01C, 32'h1);
`endif
        apb_wr(12'h01C, 32'h0);
        apb_wr(12'h104, 32'hF);

        // IRQ masking with ch2 matching every cycle
        apb_wr(12'h024, 32'd0);
        apb_wr(12'h028, 32'd0);
        apb_wr(12'h02C, 32'h1);
        apb_wr(12'h02C, 32'h0);
        rd_chk("irq_ris", 12'h104, 32'h4);
        check("irq_masked", 32'(irq), 32'h0);
        rd_chk("irq_mis0", 12'h108, 32'h0);
        apb_wr(12'h100, 32'h4);
        check("irq_enabled", 32'(irq), 32'h1);
        rd_chk("irq_mis4", 12'h108, 32'h4);
        apb_wr(12'h104, 32'h4);
        rd_chk("irq_w1c_ris", 12'h104, 32'h0);
        check("irq_w1c_irq", 32'(irq), 32'h0);
        apb_wr(12'h02C, 32'h1);
        apb_wr(12'h104, 32'h4);
        rd_chk("irq_set_wins", 12'h104, 32'h4);
        apb_wr(12'h02C, 32'h0);
        apb_wr(12'h104, 32'hF);
        apb_wr(12'h100, 32'h0);
        rd_chk("irq_final_ris", 12'h104, 32'h0);

        // Wrap boundary on ch3
        apb_wr(12'h038, 32'hFFFFFFFF);
        apb_wr(12'h030, 32'hFFFFFFFE);
        apb_wr(12'h034, 32'd0);
        mon_clr();
        apb_wr(12'h03C, 32'h1);
        e0 = wr_cyc;
        wait_cyc(e0 + 3);
        check("wrap_count", 32'(evt_cnt[3]), 32'd1);
        check("wrap_edge",  32'(first_evt[3] - e0), 32'd2);
        apb_wr(12'h03C, 32'h0);
        rd_chk("wrap_cnt", 12'h030, 32'(wr_cyc - (e0 + 2)));
        rd_chk("wrap_ris", 12'h104, 32'h8);
        apb_wr(12'h104, 32'hF);

        // CNT write on the edge that would match
        apb_wr(12'h038, 32'd5);
        apb_wr(12'h030, 32'd4);
        mon_clr();
        apb_wr(12'h03C, 32'h1);
        apb_wr(12'h030, 32'h100);
        e1 = wr_cyc;
        apb_wr(12'h03C, 32'h0);
        check("cntwr_no_evt", 32'(evt_cnt[3]), 32'd0);
        rd_chk("cntwr_value", 12'h030, 32'(32'h100 + (wr_cyc - e1)));
        rd_chk("cntwr_ris", 12'h104, 32'h0);

        // Reset mid-count with a match due on the reset edge
        apb_wr(12'h004, 32'd0);
        apb_wr(12'h008, 32'd3);
        apb_wr(12'h000, 32'd0);
        apb_wr(12'h100, 32'h1);
        apb_wr(12'h00C, 32'h1);
        e0 = wr_cyc;
        wait_cyc(e0 + 7);
        check("mid_irq_pre", 32'(irq), 32'h1);
        rst = 1'b1;
        mon_clr();
        @(posedge clk); #1;
        check("mid_evt", 32'(evt), 32'h0);
        check("mid_irq", 32'(irq), 32'h0);
        check("mid_prdata", bus.PRDATA, 32'h0);
        check("mid_slverr", 32'(bus.PSLVERR), 32'h0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_no_resume", 32'(evt_cnt[0]), 32'd0);
        rd_chk("mid_cnt",   12'h000, 32'h0);
        rd_chk("mid_ctrl",  12'h00C, 32'h0);
        rd_chk("mid_irqen", 12'h100, 32'h0);
        rd_chk("mid_ris",   12'h104, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
